// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a scanned active-low 7-segment bus.
// Each digit has its own stability filter and a sticky illegal-glyph flag.
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en_i,
    input  logic [6:0]            seg_i,
    input  logic [DIGITS-1:0]     dig_sel_i,
    input  logic                  clr_err_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     digit_valid_o,
    output logic [DIGITS-1:0]     err_o,
    output logic                  update_o
);

    localparam int         IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] C_STABLE = 4'(STABLE_CNT);

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BLANK  = 2'd1,
        CLS_NIBBLE = 2'd2
    } cls_t;

    cls_t                r_cand     [DIGITS];
    logic [3:0]          r_cand_nib [DIGITS];
    logic [3:0]          r_cnt      [DIGITS];
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_valid;
    logic [DIGITS-1:0]   r_err;
    logic                r_update;

    cls_t                w_cls;
    logic [3:0]          w_nib;
    logic                w_illegal;
    logic [IDX_W-1:0]    w_idx;
    logic                w_accept;
    logic                w_same;
    logic [3:0]          w_cnt_cur;
    logic [3:0]          w_old_nib;
    logic                w_commit;
    logic                w_changed;
    logic [DIGITS-1:0]   w_err_set;

    always_comb begin
        w_cls     = CLS_NIBBLE;
        w_nib     = 4'h0;
        w_illegal = 1'b0;
        case (seg_i)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            7'h7F: w_cls = CLS_BLANK;
            default: begin
                w_cls     = CLS_NONE;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_sel_i[k]) begin
                w_idx = IDX_W'(k);
            end
        end
    end

    // Only the selected digit's filter is touched, so all compares work on one slot.
    assign w_accept  = sample_en_i && $onehot(dig_sel_i);
    assign w_cnt_cur = r_cnt[w_idx];
    assign w_old_nib = r_value[{w_idx, 2'b00} +: 4];
    assign w_same    = (r_cand[w_idx] == w_cls) &&
                       ((w_cls != CLS_NIBBLE) || (r_cand_nib[w_idx] == w_nib));
    assign w_commit  = w_accept && !w_illegal && w_same && (w_cnt_cur == C_STABLE - 4'd1);
    assign w_changed = (w_cls == CLS_NIBBLE) ? (!r_valid[w_idx] || (w_old_nib != w_nib))
                                             : r_valid[w_idx];
    assign w_err_set = (w_accept && w_illegal) ? dig_sel_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DIGITS; k++) begin
                r_cand[k]     <= CLS_NONE;
                r_cand_nib[k] <= 4'h0;
                r_cnt[k]      <= 4'd0;
            end
            r_value  <= '0;
            r_valid  <= '0;
            r_err    <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= w_commit && w_changed;
            // A set on the same cycle as a clear must survive.
            r_err    <= (clr_err_i ? '0 : r_err) | w_err_set;
            if (w_accept) begin
                if (w_illegal) begin
                    r_cand[w_idx] <= CLS_NONE;
                    r_cnt[w_idx]  <= 4'd0;
                end else if (w_same) begin
                    if (w_cnt_cur != C_STABLE) begin
                        r_cnt[w_idx] <= w_cnt_cur + 4'd1;
                    end
                end else begin
                    r_cand[w_idx]     <= w_cls;
                    r_cand_nib[w_idx] <= w_nib;
                    r_cnt[w_idx]      <= 4'd1;
                end
            end
            if (w_commit) begin
                if (w_cls == CLS_NIBBLE) begin
                    r_value[{w_idx, 2'b00} +: 4] <= w_nib;
                    r_valid[w_idx]               <= 1'b1;
                end else begin
                    r_valid[w_idx] <= 1'b0;
                end
            end
        end
    end

    assign value_o       = r_value;
    assign digit_valid_o = r_valid;
    assign err_o         = r_err;
    assign update_o      = r_update;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random traffic,
// checked against a history-based model and an update_o scoreboard.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en_i = 1'b0;
    logic [6:0]  seg_i = 7'h7F;
    logic [3:0]  dig_sel_i = 4'h0;
    logic        clr_err_i = 1'b0;
    logic [15:0] value_o;
    logic [3:0]  digit_valid_o;
    logic [3:0]  err_o;
    logic        update_o;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(STABLE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_en_i   (sample_en_i),
        .seg_i         (seg_i),
        .dig_sel_i     (dig_sel_i),
        .clr_err_i     (clr_err_i),
        .value_o       (value_o),
        .digit_valid_o (digit_valid_o),
        .err_o         (err_o),
        .update_o      (update_o)
    );

    always #5 clk = ~clk;

    logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_upd = 0;
    logic [15:0] exp_value = '0;
    logic [3:0]  exp_valid = '0;
    logic [3:0]  exp_err = '0;
    logic [19:0] sbq [$];
    int          hist [DIGITS][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0..15 nibble, 16 blank, -1 illegal
    function automatic int glyph_code(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (s == glyph[i]) return i;
        end
        if (s == 7'h7F) return 16;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) hist[i].delete();
        exp_value = '0;
        exp_valid = '0;
        exp_err   = '0;
        sbq.delete();
    endtask

    // A digit commits when its last STABLE legal samples agree and that run is new.
    task automatic drive(input logic en, input logic [3:0] sel, input logic [6:0] seg,
                         input logic clr);
        int          k;
        int          code;
        int          n;
        bit          commit;
        bit          push;
        logic [15:0] nv;
        logic [3:0]  nvl;
        logic [3:0]  ne;
        @(negedge clk);
        sample_en_i = en;
        dig_sel_i   = sel;
        seg_i       = seg;
        clr_err_i   = clr;
        nv   = exp_value;
        nvl  = exp_valid;
        ne   = clr ? 4'b0 : exp_err;
        push = 1'b0;
        k    = 0;
        if (en && $countones(sel) == 1) begin
            for (int i = 0; i < DIGITS; i++) if (sel[i]) k = i;
            code = glyph_code(seg);
            if (code < 0) begin
                ne[k] = 1'b1;
                hist[k].delete();
            end else begin
                hist[k].push_back(code);
                if (hist[k].size() > STABLE + 1) void'(hist[k].pop_front());
                n      = hist[k].size();
                commit = (n >= STABLE);
                for (int j = n - STABLE; j < n && commit; j++)
                    if (hist[k][j] != code) commit = 1'b0;
                if (commit && n == STABLE + 1 && hist[k][0] == code) commit = 1'b0;
                if (commit) begin
                    if (code < 16) begin
                        nv[k*4 +: 4] = 4'(code);
                        nvl[k]       = 1'b1;
                    end else begin
                        nvl[k] = 1'b0;
                    end
                    push = (nv != exp_value) || (nvl != exp_valid);
                end
            end
        end
        @(posedge clk);
        #1;
        exp_value = nv;
        exp_valid = nvl;
        exp_err   = ne;
        if (push) sbq.push_back({nv, nvl});
        sample_en_i = 1'b0;
        clr_err_i   = 1'b0;
    endtask

    task automatic samp(input int d, input logic [6:0] seg);
        drive(1'b1, 4'(1 << d), seg, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_value", 32'(value_o), 32'h0);
        check("reset_valid", 32'(digit_valid_o), 32'h0);
        check("reset_err", 32'(err_o), 32'h0);
        check("reset_update", 32'(update_o), 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: state compare every cycle, update_o pulses popped from the scoreboard.
    always @(negedge clk) begin
        check("value_o", 32'(value_o), 32'(exp_value));
        check("digit_valid_o", 32'(digit_valid_o), 32'(exp_valid));
        check("err_o", 32'(err_o), 32'(exp_err));
        if (update_o) begin
            n_upd++;
            if (sbq.size() == 0) begin
                check("spurious_update", 32'(update_o), 32'h0);
            end else begin
                check("update_snapshot", 32'({value_o, digit_valid_o}), 32'(sbq.pop_front()));
            end
        end else if (sbq.size() != 0) begin
            check("missing_update", 32'(update_o), 32'h1);
            void'(sbq.pop_front());
        end
    end

    initial begin
        int          p;
        logic [6:0]  fav [DIGITS];
        logic [3:0]  sel;
        logic [6:0]  sg;
        int          d;
        int          r;

        do_reset();
        p = n_upd;
        repeat (3) samp(0, 7'h40);
        settle();
        check("d0_value", 32'(value_o[3:0]), 32'h0);
        check("d0_valid", 32'(digit_valid_o), 32'h1);
        check("d0_pulses", 32'(n_upd - p), 32'd1);
        samp(0, 7'h40);
        settle();
        check("d0_saturated_pulses", 32'(n_upd - p), 32'd1);

        do_reset();
        p = n_upd;
        repeat (3) begin
            samp(0, 7'h12);
            samp(1, 7'h03);
            samp(2, 7'h21);
            samp(3, 7'h0E);
        end
        settle();
        check("rr_value", 32'(value_o), 32'hFDB5);
        check("rr_valid", 32'(digit_valid_o), 32'hF);
        check("rr_pulses", 32'(n_upd - p), 32'd4);

        do_reset();
        p = n_upd;
        samp(2, 7'h79);
        samp(2, 7'h79);
        repeat (3) samp(2, 7'h24);
        settle();
        check("d2_value", 32'(value_o[11:8]), 32'h2);
        check("d2_valid", 32'(digit_valid_o), 32'h4);
        check("d2_pulses", 32'(n_upd - p), 32'd1);

        do_reset();
        repeat (3) samp(1, 7'h30);
        samp(1, 7'h7F);
        samp(1, 7'h55);
        settle();
        check("err_set", 32'(err_o), 32'h2);
        check("err_value_held", 32'(value_o[7:4]), 32'h3);
        drive(1'b1, 4'b0010, 7'h55, 1'b1);
        settle();
        check("err_set_beats_clear", 32'(err_o), 32'h2);
        drive(1'b0, 4'b0000, 7'h7F, 1'b1);
        settle();
        check("err_cleared", 32'(err_o), 32'h0);

        do_reset();
        repeat (3) samp(3, 7'h00);
        settle();
        p = n_upd;
        repeat (3) samp(3, 7'h7F);
        settle();
        check("blank_valid", 32'(digit_valid_o[3]), 32'h0);
        check("blank_value_held", 32'(value_o[15:12]), 32'h8);
        check("blank_pulses", 32'(n_upd - p), 32'd1);
        p = n_upd;
        repeat (3) drive(1'b1, 4'b0011, 7'h55, 1'b0);
        repeat (3) drive(1'b1, 4'b0000, 7'h40, 1'b0);
        settle();
        check("bad_sel_value", 32'(value_o), 32'h8000);
        check("bad_sel_valid", 32'(digit_valid_o), 32'h0);
        check("bad_sel_err", 32'(err_o), 32'h0);
        check("bad_sel_pulses", 32'(n_upd - p), 32'd0);

        do_reset();
        repeat (3) samp(1, 7'h79);
        samp(2, 7'h55);
        samp(0, 7'h40);
        samp(0, 7'h40);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_value", 32'(value_o), 32'h0);
        check("async_rst_valid", 32'(digit_valid_o), 32'h0);
        check("async_rst_err", 32'(err_o), 32'h0);
        settle();
        rst_n = 1'b1;
        p = n_upd;
        samp(0, 7'h40);
        samp(0, 7'h40);
        settle();
        check("post_rst_no_commit", 32'(digit_valid_o), 32'h0);
        check("post_rst_pulses", 32'(n_upd - p), 32'd0);

        for (int i = 0; i < DIGITS; i++) fav[i] = glyph[$urandom_range(0, 15)];
        for (int it = 0; it < 3000; it++) begin
            d = $urandom_range(0, DIGITS - 1);
            r = $urandom_range(0, 9);
            if (r == 0)      sel = 4'h0;
            else if (r == 1) sel = 4'(1 << d) | 4'(1 << ((d + 1) % DIGITS));
            else             sel = 4'(1 << d);
            if ($urandom_range(0, 5) == 0) fav[d] = ($urandom_range(0, 3) == 0) ? 7'h7F
                                                   : glyph[$urandom_range(0, 15)];
            r = $urandom_range(0, 15);
            if (r == 0)      sg = 7'($urandom_range(0, 127));
            else             sg = fav[d];
            drive($urandom_range(0, 7) != 0, sel, sg, $urandom_range(0, 19) == 0);
        end
        settle();
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
